// File: rtl/image_processing_ip_if.sv
// AXI4-Stream beat bundle shared by the pixel
// processor's input and output ports.
interface image_processing_ip_if #(
  parameter int W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/image_processing_ip.sv
// Per-pixel xRGB processor: pass, invert, gray, threshold.
// One holding register between MM2S and S2MM streams.
module image_processing_ip #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int COEF_R = 77,
  parameter int COEF_G = 150,
  parameter int COEF_B = 29
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  cfg_threshold,
  image_processing_ip_if.slave  s_axis_mm2s,
  image_processing_ip_if.master m_axis_s2mm,
  output logic [31:0] beat_count
);

  logic [C_AXIS_TDATA_WIDTH-1:0] r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic [31:0] r_beat_count;

  logic        w_tready;
  logic        w_accept;
  logic        w_xfer;
  logic [7:0]  w_r;
  logic [7:0]  w_g;
  logic [7:0]  w_b;
  logic [15:0] w_luma_sum;
  logic [7:0]  w_y;
  logic [31:0] w_result;

  assign w_tready = ~areset & (~r_tvalid | m_axis_s2mm.tready);
  assign w_accept = s_axis_mm2s.tvalid & w_tready;
  assign w_xfer   = r_tvalid & m_axis_s2mm.tready;

  assign w_r = s_axis_mm2s.tdata[23:16];
  assign w_g = s_axis_mm2s.tdata[15:8];
  assign w_b = s_axis_mm2s.tdata[7:0];

  // Weights sum to 256, so the 16-bit sum cannot overflow.
  assign w_luma_sum = 16'(w_r) * 16'(COEF_R)
                    + 16'(w_g) * 16'(COEF_G)
                    + 16'(w_b) * 16'(COEF_B);
  assign w_y = w_luma_sum[15:8];

  always_comb begin
    w_result = s_axis_mm2s.tdata;
    unique case (cfg_mode)
      2'd0: w_result = s_axis_mm2s.tdata;
      2'd1: w_result = ~s_axis_mm2s.tdata;
      2'd2: w_result = {8'h00, w_y, w_y, w_y};
      2'd3: w_result = (w_y >= cfg_threshold) ?
                       32'h00FF_FFFF : 32'h0000_0000;
      default: w_result = s_axis_mm2s.tdata;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_beat_count <= '0;
    end else begin
      if (w_xfer)
        r_beat_count <= r_beat_count + 32'd1;
      if (w_accept) begin
        r_tdata  <= w_result;
        r_tlast  <= s_axis_mm2s.tlast;
        r_tvalid <= 1'b1;
      end else if (w_xfer) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign s_axis_mm2s.tready = w_tready;
  assign m_axis_s2mm.tdata  = r_tdata;
  assign m_axis_s2mm.tvalid = r_tvalid;
  assign m_axis_s2mm.tlast  = r_tlast;
  assign beat_count         = r_beat_count;

endmodule

// File: tb/tb_image_processing_ip.sv
// Scoreboard bench for image_processing_ip: directed
// cases plus randomized beats against a luma model.
module tb_image_processing_ip;

  logic        clk = 1'b0;
  logic        areset;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_thr;
  logic [31:0] beat_count;

  always #5 clk = ~clk;

  image_processing_ip_if s_if ();
  image_processing_ip_if m_if ();

  image_processing_ip dut (
    .aclk          (clk),
    .areset        (areset),
    .cfg_mode      (cfg_mode),
    .cfg_threshold (cfg_thr),
    .s_axis_mm2s   (s_if),
    .m_axis_s2mm   (m_if),
    .beat_count    (beat_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] sbq[$];
  bit   armed = 1'b0;
  bit   rnd_ready = 1'b0;
  int   exp_cnt = 0;
  bit   prev_stall = 1'b0;
  bit   prev_acc = 1'b0;
  logic [32:0] prev_out = '0;

  function automatic logic [31:0] ref_pix(
    input logic [1:0] mode,
    input logic [7:0] thr,
    input logic [31:0] d
  );
    int y;
    logic [7:0] y8;
    y = (int'(d[23:16]) * 77 + int'(d[15:8]) * 150
         + int'(d[7:0]) * 29) / 256;
    y8 = y[7:0];
    case (mode)
      2'd0: return d;
      2'd1: return ~d;
      2'd2: return {8'h00, y8, y8, y8};
      default: return (y >= int'(thr)) ? 32'h00FF_FFFF : 32'h0;
    endcase
  endfunction

  task automatic check(
    input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer.
  always @(negedge clk) begin
    if (areset) begin
      check("s_tready_in_reset", 64'(s_if.tready), 64'd0);
      sbq.delete();
      exp_cnt = 0;
      prev_stall = 1'b0;
      prev_acc = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      check("beat_count", 64'(beat_count), 64'(exp_cnt));
      check("s_tready", 64'(s_if.tready),
            64'(!m_if.tvalid || m_if.tready));
      if (prev_acc)
        check("latency_tvalid", 64'(m_if.tvalid), 64'd1);
      if (prev_stall) begin
        check("hold_tvalid", 64'(m_if.tvalid), 64'd1);
        check("hold_beat", 64'({m_if.tlast, m_if.tdata}),
              64'(prev_out));
      end
      if (m_if.tvalid && m_if.tready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: got %h expected none",
                   {m_if.tlast, m_if.tdata});
        end else begin
          check("out_beat", 64'({m_if.tlast, m_if.tdata}),
                64'(sbq.pop_front()));
        end
        exp_cnt++;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_out = {m_if.tlast, m_if.tdata};
      prev_acc = s_if.tvalid && s_if.tready;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready)
      m_if.tready = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [31:0] d,
    input logic l,
    input logic [1:0] m,
    input logic [7:0] t,
    input logic [31:0] e
  );
    bit acc;
    acc = 1'b0;
    s_if.tdata = d;
    s_if.tlast = l;
    s_if.tvalid = 1'b1;
    cfg_mode = m;
    cfg_thr = t;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (s_if.tready && !areset) begin
        acc = 1'b1;
        sbq.push_back({l, e});
      end
      step();
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    s_if.tvalid = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (sbq.size() == 0 && !m_if.tvalid) done = 1'b1;
      else step();
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sbq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  m;
    logic [7:0]  t;
    logic        l;

    areset = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    cfg_mode = 2'd0;
    cfg_thr = 8'd0;
    repeat (3) step();
    areset = 1'b0;
    @(negedge clk);
    check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_tdata", 64'(m_if.tdata), 64'd0);
    check("rst_tlast", 64'(m_if.tlast), 64'd0);
    check("rst_count", 64'(beat_count), 64'd0);
    step();

    send(32'h1234_5678, 1'b0, 2'd0, 8'h00, 32'h1234_5678);
    send(32'hA5A5_A5A5, 1'b1, 2'd0, 8'h00, 32'hA5A5_A5A5);
    drain();
    check("count_after_pass", 64'(beat_count), 64'd2);

    send(32'h0000_0000, 1'b0, 2'd1, 8'h00, 32'hFFFF_FFFF);
    send(32'hFFFF_FFFF, 1'b0, 2'd1, 8'h00, 32'h0000_0000);

    send(32'h00FF_0000, 1'b0, 2'd2, 8'h00, 32'h004C_4C4C);
    send(32'h0000_FF00, 1'b0, 2'd2, 8'h00, 32'h0095_9595);
    send(32'h0000_00FF, 1'b0, 2'd2, 8'h00, 32'h001C_1C1C);
    send(32'hFFFF_FFFF, 1'b1, 2'd2, 8'h00, 32'h00FF_FFFF);

    send(32'h00FF_0000, 1'b0, 2'd3, 8'h80, 32'h0000_0000);
    send(32'h0000_FF00, 1'b0, 2'd3, 8'h80, 32'h00FF_FFFF);
    send(32'h0000_FF00, 1'b0, 2'd3, 8'h95, 32'h00FF_FFFF);
    send(32'h0000_FF00, 1'b0, 2'd3, 8'h96, 32'h0000_0000);
    send(32'h0000_0000, 1'b1, 2'd3, 8'h00, 32'h00FF_FFFF);
    drain();

    m_if.tready = 1'b0;
    send(32'h1111_1111, 1'b0, 2'd0, 8'h00, 32'h1111_1111);
    fork
      send(32'h2222_2222, 1'b1, 2'd1, 8'h00, 32'hDDDD_DDDD);
      begin
        repeat (3) step();
        check("stall_s_tready", 64'(s_if.tready), 64'd0);
        m_if.tready = 1'b1;
      end
    join
    drain();

    m_if.tready = 1'b0;
    send(32'h3333_3333, 1'b1, 2'd1, 8'h00, 32'hCCCC_CCCC);
    s_if.tvalid = 1'b0;
    areset = 1'b1;
    step();
    areset = 1'b0;
    check("mid_rst_tvalid", 64'(m_if.tvalid), 64'd0);
    check("mid_rst_tdata", 64'(m_if.tdata), 64'd0);
    check("mid_rst_count", 64'(beat_count), 64'd0);
    m_if.tready = 1'b1;
    send(32'h00FF_0000, 1'b1, 2'd2, 8'h00, 32'h004C_4C4C);
    drain();
    check("count_after_rst", 64'(beat_count), 64'd1);

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        idle($urandom_range(1, 2));
      d = $urandom;
      m = 2'($urandom_range(0, 3));
      t = 8'($urandom_range(0, 255));
      l = 1'($urandom_range(0, 1));
      send(d, l, m, t, ref_pix(m, t, d));
    end
    s_if.tvalid = 1'b0;
    rnd_ready = 1'b0;
    step();
    m_if.tready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/image_processing_ip.md
Name: image_processing_ip

Overview:
- Single-clock AXI4-Stream pixel processor between the MM2S DMA read channel and the S2MM DMA write channel.
- Accepts one 32-bit xRGB pixel per beat and applies a selectable per-pixel operation: passthrough, invert, grayscale or binary threshold.
- Emits the result on an AXI4-Stream master with one register stage of latency and full backpressure support.

Parameters:
- C_AXIS_TDATA_WIDTH, 32: stream data width; only 32 is supported.
- COEF_R, 77: red luma weight (Q0.8).
- COEF_G, 150: green luma weight (Q0.8).
- COEF_B, 29: blue luma weight (Q0.8); COEF_R+COEF_G+COEF_B must equal 256.

Ports:
- aclk  in  1  sole clock; all logic rising-edge.
- areset  in  1  synchronous, active-high reset.
- cfg_mode  in  2  operation select: 0 pass, 1 invert, 2 gray, 3 threshold.
- cfg_threshold  in  8  luma threshold for mode 3.
- s_axis_mm2s_tdata  in  32  input pixel: [23:16]=R, [15:8]=G, [7:0]=B, [31:24]=X.
- s_axis_mm2s_tvalid  in  1  input beat valid.
- s_axis_mm2s_tlast  in  1  end of line/frame marker.
- s_axis_mm2s_tready  out  1  input beat accepted when high with tvalid.
- m_axis_s2mm_tdata  out  32  processed pixel.
- m_axis_s2mm_tvalid  out  1  output beat valid.
- m_axis_s2mm_tlast  out  1  copy of the accepted input tlast.
- m_axis_s2mm_tready  in  1  downstream ready.
- beat_count  out  32  number of output beats transferred since reset.

Behaviour:
- Reset (areset=1 at a clock edge): m_axis_s2mm_tvalid=0, m_axis_s2mm_tdata=0, m_axis_s2mm_tlast=0, beat_count=0. While areset is high, s_axis_mm2s_tready=0 and no beat is accepted.
- Reset mid-operation: any held output beat is discarded. The first beat after reset deasserts is treated as fresh.
- s_axis_mm2s_tready = ~areset & (~m_axis_s2mm_tvalid | m_axis_s2mm_tready). This is combinational, so a full-throughput, one-beat-per-cycle stream flows when downstream is always ready.
- Input accept = s_axis_mm2s_tvalid & s_axis_mm2s_tready. Output transfer = m_axis_s2mm_tvalid & m_axis_s2mm_tready.
- On accept: the output register loads f(tdata) and tlast, and m_axis_s2mm_tvalid is set to 1. Latency is exactly 1 cycle from accept to tvalid.
- On transfer without a simultaneous accept: m_axis_s2mm_tvalid clears to 0.
- On transfer with a simultaneous accept: the register reloads and tvalid stays 1; no bubble is inserted.
- While tvalid=1 and tready=0: tdata and tlast hold stable (AXI rule), and s_axis_mm2s_tready=0.
- cfg_mode and cfg_threshold are sampled at accept time, per beat. Changing them never alters a beat already held.
- Luma: Y = (R*COEF_R + G*COEF_G + B*COEF_B) >> 8. Use a 16-bit unsigned intermediate. Truncate (no rounding); Y is 8 bits.
- mode 0: out = in, including the X byte.
- mode 1: out = ~in, all 32 bits.
- mode 2: out = {8'h00, Y, Y, Y}.
- mode 3: out = (Y >= cfg_threshold) ? 32'h00FFFFFF : 32'h00000000. Equality counts as white; threshold 0 gives all white.
- beat_count increments by 1 on every output transfer and wraps from 0xFFFFFFFF to 0.
- tlast has no effect on processing; it is only propagated.
- No internal state machine beyond the single output holding register plus the counter.

Test Plan:
- Reset, then hold m_tready=1 and stream tvalid=1 in mode 0 with 0x12345678 followed by 0xA5A5A5A5 (tlast on the second) -> outputs appear one cycle later, back-to-back; tlast only on 0xA5A5A5A5; beat_count=2.
- Mode 1, input 0x00000000 then 0xFFFFFFFF -> outputs 0xFFFFFFFF then 0x00000000.
- Mode 2, inputs 0x00FF0000, 0x0000FF00, 0x000000FF, 0xFFFFFFFF -> outputs 0x004C4C4C, 0x00959595, 0x001C1C1C, 0x00FFFFFF.
- Mode 3 with threshold 0x80, inputs 0x00FF0000 (Y=0x4C) and 0x0000FF00 (Y=0x95) -> 0x00000000 and 0x00FFFFFF. With threshold 0x95 on the green input -> 0x00FFFFFF (equality case).
- Backpressure: drop m_tready for 3 cycles while an output is valid -> tdata and tlast stay stable, s_tready=0, and no input is lost. After tready returns, the sequence arrives in order with no duplicates.
- Assert areset for 1 cycle while an output is valid and stalled -> next cycle tvalid=0, tdata=0 and beat_count=0. After reset, a new beat is processed normally.
